// File: rtl/avalon_io_interface.sv
// avalon_io_interface: Avalon-MM slave for board LEDs, switches and keys.
// Synchronizes SW_IN, synchronizes and debounces KEY_IN, and latches key
// presses in a write-1-to-clear EDGE register.
// Build option: define IO_IRQ_EN to add the MASK register and IRQ output.
// Ports:
//   CLK, RESET       clock, synchronous active-high reset
//   AVL_CS/READ/WRITE/ADDR/BYTE_EN/WRITEDATA  slave command
//   AVL_READDATA     read data, latency 1, holds between reads
//   SW_IN, KEY_IN    raw board inputs (KEY_IN active-low)
//   LED_OUT, IRQ     LED drive, level interrupt
// Map: 0 LED, 1 SW, 2 KEY, 3 EDGE, 4 MASK, 5-7 zero.
module avalon_io_interface #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        AVL_CS,
   input  logic        AVL_READ,
   input  logic        AVL_WRITE,
   input  logic [2:0]  AVL_ADDR,
   input  logic [3:0]  AVL_BYTE_EN,
   input  logic [31:0] AVL_WRITEDATA,
   output logic [31:0] AVL_READDATA,
   input  logic [7:0]  SW_IN,
   input  logic [1:0]  KEY_IN,
   output logic [7:0]  LED_OUT,
   output logic        IRQ
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [7:0]    sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
   logic [1:0]    key_s1_q, key_s1_d, key_s2_q, key_s2_d;
   logic [1:0]    key_q, key_d, key_prev_q, key_prev_d;
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];
   logic [1:0]    edge_q, edge_d;
   logic [7:0]    led_q, led_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [1:0]    key_lvl, edge_clr;
   logic          wr_en, rd_en, wr_b0;

   // Upper byte lanes carry no register bits.
   logic unused_ok;
   assign unused_ok = ^{AVL_BYTE_EN[3:1], AVL_WRITEDATA[31:8]};

`ifdef IO_IRQ_EN
   logic [1:0] mask_q, mask_d;
   logic       irq_q, irq_d;
`endif

   always_comb begin
      wr_en = AVL_CS & AVL_WRITE;
      rd_en = AVL_CS & AVL_READ;
      wr_b0 = wr_en & AVL_BYTE_EN[0];

      sw_s1_d  = SW_IN;
      sw_s2_d  = sw_s1_q;
      key_s1_d = KEY_IN;
      key_s2_d = key_s1_q;

      // Pressed level: keys are active-low on the board.
      key_lvl = ~key_s2_q;
      key_d   = key_q;
      for (int k = 0; k < 2; k++) begin
         if (key_lvl[k] == key_q[k]) begin
            cnt_d[k] = '0;
         end else if (cnt_q[k] == CNT_MAX) begin
            key_d[k] = key_lvl[k];
            cnt_d[k] = '0;
         end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
         end
      end
      key_prev_d = key_q;

      // Set term is ORed last so a new press beats a same-cycle clear.
      edge_clr = (wr_b0 && AVL_ADDR == 3'd3) ?
                 AVL_WRITEDATA[1:0] : 2'b00;
      edge_d   = (edge_q & ~edge_clr) | (key_q & ~key_prev_q);

      led_d = led_q;
      if (wr_b0 && AVL_ADDR == 3'd0)
         led_d = AVL_WRITEDATA[7:0];

`ifdef IO_IRQ_EN
      mask_d = mask_q;
      if (wr_b0 && AVL_ADDR == 3'd4)
         mask_d = AVL_WRITEDATA[1:0];
      irq_d = |(edge_q & mask_q);
`endif

      rdata_d = rdata_q;
      if (rd_en) begin
         unique case (AVL_ADDR)
            3'd0:    rdata_d = {24'd0, led_q};
            3'd1:    rdata_d = {24'd0, sw_s2_q};
            3'd2:    rdata_d = {30'd0, key_q};
            3'd3:    rdata_d = {30'd0, edge_q};
`ifdef IO_IRQ_EN
            3'd4:    rdata_d = {30'd0, mask_q};
`endif
            default: rdata_d = 32'd0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sw_s1_q    <= '0;
         sw_s2_q    <= '0;
         key_s1_q   <= 2'b11;
         key_s2_q   <= 2'b11;
         key_q      <= '0;
         key_prev_q <= '0;
         cnt_q[0]   <= '0;
         cnt_q[1]   <= '0;
         edge_q     <= '0;
         led_q      <= '0;
         rdata_q    <= '0;
`ifdef IO_IRQ_EN
         mask_q     <= '0;
         irq_q      <= 1'b0;
`endif
      end else begin
         sw_s1_q    <= sw_s1_d;
         sw_s2_q    <= sw_s2_d;
         key_s1_q   <= key_s1_d;
         key_s2_q   <= key_s2_d;
         key_q      <= key_d;
         key_prev_q <= key_prev_d;
         cnt_q[0]   <= cnt_d[0];
         cnt_q[1]   <= cnt_d[1];
         edge_q     <= edge_d;
         led_q      <= led_d;
         rdata_q    <= rdata_d;
`ifdef IO_IRQ_EN
         mask_q     <= mask_d;
         irq_q      <= irq_d;
`endif
      end
   end

   assign AVL_READDATA = rdata_q;
   assign LED_OUT      = led_q;
`ifdef IO_IRQ_EN
   assign IRQ = irq_q;
`else
   assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_io_interface.sv
// tb_avalon_io_interface: directed and random stimulus for
// avalon_io_interface, checked against a behavioural model.
module tb_avalon_io_interface;

   localparam int DEB = 4;
`ifdef IO_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cs, rd, wr;
   logic [2:0]  addr;
   logic [3:0]  be;
   logic [31:0] wd;
   logic [31:0] rdata;
   logic [7:0]  sw;
   logic [1:0]  key;
   logic [7:0]  led;
   logic        irq;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   avalon_io_interface #(.DEBOUNCE_CYCLES(DEB)) dut (
      .CLK          (clk),
      .RESET        (rst),
      .AVL_CS       (cs),
      .AVL_READ     (rd),
      .AVL_WRITE    (wr),
      .AVL_ADDR     (addr),
      .AVL_BYTE_EN  (be),
      .AVL_WRITEDATA(wd),
      .AVL_READDATA (rdata),
      .SW_IN        (sw),
      .KEY_IN       (key),
      .LED_OUT      (led),
      .IRQ          (irq)
   );

   // Behavioural model: input histories as queues, debounce as a
   // run length of disagreeing samples.
   logic [7:0]  m_led;
   logic [7:0]  m_sw_h[$];
   logic [1:0]  m_key_h[$];
   logic [1:0]  m_stab, m_rose, m_edge, m_mask;
   logic        m_irq;
   logic [31:0] m_rdata;
   int          m_run[2];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      logic [1:0] lvl, clr, stab_n;
      logic       wr_en;
      if (rst) begin
         m_led   = '0;
         m_sw_h  = '{8'h00, 8'h00};
         m_key_h = '{2'b11, 2'b11};
         m_stab  = '0;
         m_rose  = '0;
         m_edge  = '0;
         m_mask  = '0;
         m_irq   = 1'b0;
         m_rdata = '0;
         m_run[0] = 0;
         m_run[1] = 0;
         return;
      end
      wr_en = cs & wr;
      if (cs & rd) begin
         case (addr)
            3'd0:    m_rdata = {24'd0, m_led};
            3'd1:    m_rdata = {24'd0, m_sw_h[0]};
            3'd2:    m_rdata = {30'd0, m_stab};
            3'd3:    m_rdata = {30'd0, m_edge};
            3'd4:    m_rdata = {30'd0, m_mask};
            default: m_rdata = 32'd0;
         endcase
      end
      m_irq  = IRQ_EN && ((m_edge & m_mask) != 2'b00);
      clr    = (wr_en && be[0] && addr == 3'd3) ? wd[1:0] : 2'b00;
      m_edge = (m_edge & ~clr) | m_rose;
      lvl    = ~m_key_h[0];
      stab_n = m_stab;
      for (int k = 0; k < 2; k++) begin
         if (lvl[k] == m_stab[k]) begin
            m_run[k] = 0;
         end else begin
            m_run[k]++;
            if (m_run[k] == DEB) begin
               stab_n[k] = lvl[k];
               m_run[k]  = 0;
            end
         end
      end
      m_rose = stab_n & ~m_stab;
      m_stab = stab_n;
      if (wr_en && be[0]) begin
         if (addr == 3'd0) m_led = wd[7:0];
         if (IRQ_EN && addr == 3'd4) m_mask = wd[1:0];
      end
      m_sw_h.push_back(sw);
      void'(m_sw_h.pop_front());
      m_key_h.push_back(key);
      void'(m_key_h.pop_front());
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("led", {24'd0, led}, {24'd0, m_led});
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
      chk("rdata", rdata, m_rdata);
   endtask

   task automatic bus(input logic c, input logic r, input logic w,
                      input logic [2:0] a, input logic [3:0] b,
                      input logic [31:0] d);
      cs = c; rd = r; wr = w; addr = a; be = b; wd = d;
   endtask

   task automatic idle(input int n);
      bus(0, 0, 0, 3'd0, 4'h0, 32'd0);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst = 1'b1; sw = 8'h00; key = 2'b11;
      bus(0, 0, 0, 3'd0, 4'h0, 32'd0);
      tick(); tick();
      rst = 1'b0;

      for (int a = 0; a < 8; a++) begin
         bus(1, 1, 0, 3'(a), 4'h0, 32'd0);
         tick();
         chk("rst_read", rdata, 32'd0);
      end
      chk("rst_led", {24'd0, led}, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);

      bus(1, 0, 1, 3'd0, 4'hF, 32'h0000_00A5); tick();
      chk("led_wr", {24'd0, led}, 32'hA5);
      bus(1, 0, 1, 3'd0, 4'hE, 32'h0000_00FF); tick();
      chk("led_be", {24'd0, led}, 32'hA5);
      bus(1, 1, 0, 3'd0, 4'h0, 32'd0); tick();
      chk("led_rd", rdata, 32'hA5);
      bus(1, 1, 1, 3'd0, 4'h1, 32'h0000_005A); tick();
      chk("rw_same", rdata, 32'hA5);
      chk("rw_led", {24'd0, led}, 32'h5A);

      rst = 1'b1;
      bus(1, 1, 0, 3'd0, 4'h0, 32'd0); tick();
      chk("rst_mid_rd", rdata, 32'd0);
      rst = 1'b0;

      sw = 8'h3C;
      idle(1);
      bus(1, 1, 0, 3'd1, 4'h0, 32'd0); tick();
      chk("sw_early", rdata, 32'd0);
      tick();
      chk("sw_late", rdata, 32'h3C);

      bus(1, 0, 1, 3'd4, 4'hF, 32'h2); tick();
      bus(1, 1, 0, 3'd4, 4'h0, 32'd0); tick();
      chk("mask_rd", rdata, IRQ_EN ? 32'h2 : 32'h0);

      bus(1, 1, 0, 3'd2, 4'h0, 32'd0);
      key = 2'b01; for (int i = 0; i < 3; i++) tick();
      key = 2'b11; for (int i = 0; i < 2; i++) tick();
      key = 2'b01; for (int i = 0; i < 3; i++) tick();
      key = 2'b11; tick();
      chk("bounce_key", rdata, 32'd0);
      key = 2'b01;
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("key_settle", rdata, (i == 7) ? 32'h2 : 32'h0);
         if (i == 7) chk("irq_pre", {31'd0, irq}, 32'd0);
      end
      bus(1, 1, 0, 3'd3, 4'h0, 32'd0); tick();
      chk("edge_set", rdata, 32'h2);
      chk("irq_set", {31'd0, irq}, {31'd0, IRQ_EN});

      bus(1, 0, 1, 3'd3, 4'hF, 32'h2); tick();
      bus(1, 1, 0, 3'd3, 4'h0, 32'd0); tick();
      chk("edge_clr", rdata, 32'd0);
      chk("irq_clr", {31'd0, irq}, 32'd0);

      key = 2'b00;
      idle(6);
      bus(1, 0, 1, 3'd3, 4'hF, 32'h3); tick();
      bus(1, 1, 0, 3'd3, 4'h0, 32'd0); tick();
      chk("set_wins", rdata, 32'h1);
      tick();
      chk("irq_masked", {31'd0, irq}, 32'd0);

      key = 2'b11; idle(8);
      key = 2'b10; idle(3);
      key = 2'b11; idle(8);
      bus(1, 1, 0, 3'd2, 4'h0, 32'd0); tick();
      chk("glitch_key", rdata, 32'd0);
      bus(1, 1, 0, 3'd3, 4'h0, 32'd0); tick();
      chk("glitch_edge", rdata, 32'h1);

      for (int c = 0; c < 3000; c++) begin
         int kb;
         rst  = ($urandom_range(0, 499) == 0);
         cs   = ($urandom_range(0, 3) != 0);
         rd   = 1'($urandom);
         wr   = ($urandom_range(0, 2) == 0);
         addr = 3'($urandom);
         be   = 4'($urandom);
         wd   = $urandom;
         if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            kb = int'($urandom_range(0, 1));
            key[kb] = ~key[kb];
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
